// File: rtl/apb_arb_pkg.sv
// Shared definitions for the APB requester arbiter: FSM encoding, default widths and clog2.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StAccess = 2'd2
  } state_e;

  localparam int unsigned DefAw = 32;
  localparam int unsigned DefDw = 32;

  // Ceiling log2, usable in constant expressions.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/apb_req_arbiter_if.sv
// Requester-side handshake plus APB master bus for apb_req_arbiter.
// The master modport is the arbiter's view; the slave modport is the environment's view.
interface apb_req_arbiter_if
  import apb_arb_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned AW   = DefAw,
  parameter int unsigned DW   = DefDw
) ();

  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    req_write;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    done;
  logic [DW-1:0]      rdata;
  logic               err;

  logic               Psel;
  logic               Penable;
  logic               Pwrite;
  logic [AW-1:0]      Paddr;
  logic [DW-1:0]      Pwdata;
  logic [DW-1:0]      Prdata;
  logic               Pready;
  logic               Pslverr;

  modport master (
    input  req, req_write, req_addr, req_wdata, Prdata, Pready, Pslverr,
    output done, rdata, err, Psel, Penable, Pwrite, Paddr, Pwdata
  );

  modport slave (
    output req, req_write, req_addr, req_wdata, Prdata, Pready, Pslverr,
    input  done, rdata, err, Psel, Penable, Pwrite, Paddr, Pwdata
  );

endinterface

// File: rtl/apb_rr_arbiter.sv
// Combinational rotating-priority select: first set request at or after i_rr_ptr wins.
module apb_rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  localparam int unsigned PW  = clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_rr_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [PW-1:0]   o_idx
);

  logic          w_found;
  int unsigned   w_pos;
  logic [PW-1:0] w_j;

  // Walk NREQ positions from the pointer, wrapping, and take the first request seen.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_pos   = 0;
    w_j     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_pos = 32'(i_rr_ptr) + k;
      if (w_pos >= NREQ) w_pos = w_pos - NREQ;
      w_j = PW'(w_pos);
      if (!w_found && i_req[w_j]) begin
        w_found  = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx    = w_j;
      end
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Shares one APB master port among NREQ requesters with round-robin arbitration.
// Each grant runs one SETUP/ACCESS transfer and returns a one-cycle done pulse.
// Optional APB_TIMEOUT_EN: aborts an ACCESS phase stalled for TIMEOUT cycles with err=1.
module apb_req_arbiter
  import apb_arb_pkg::*;
#(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned AW      = DefAw,
  parameter int unsigned DW      = DefDw
`ifdef APB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT = 16
`endif
) (
  input logic                 clk,
  input logic                 rst,
  apb_req_arbiter_if.master   bus
);

  localparam int unsigned PW = clog2(NREQ);

  state_e          r_state, w_state_d;
  logic [PW-1:0]   r_rr_ptr, w_rr_ptr_d;
  logic [PW-1:0]   r_gnt_idx, w_gnt_idx_d;
  logic [NREQ-1:0] r_gnt, w_gnt_d;
  logic            r_psel, w_psel_d;
  logic            r_penable, w_penable_d;
  logic            r_pwrite, w_pwrite_d;
  logic [AW-1:0]   r_paddr, w_paddr_d;
  logic [DW-1:0]   r_pwdata, w_pwdata_d;
  logic [NREQ-1:0] r_done, w_done_d;
  logic [DW-1:0]   r_rdata, w_rdata_d;
  logic            r_err, w_err_d;

  logic [NREQ-1:0] w_arb_gnt;
  logic [PW-1:0]   w_arb_idx;
  logic            w_timeout;
  logic            w_complete;

  apb_rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr_arbiter (
    .i_req    (bus.req),
    .i_rr_ptr (r_rr_ptr),
    .o_gnt    (w_arb_gnt),
    .o_idx    (w_arb_idx)
  );

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CW = clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt, w_cnt_d;

  // Abort at the edge where the stall count would reach TIMEOUT.
  assign w_timeout = (r_state == StAccess) && !bus.Pready && (r_cnt == CW'(TIMEOUT - 1));

  // Stall counter: cleared entering ACCESS, counts ACCESS cycles without Pready.
  always_comb begin
    w_cnt_d = r_cnt;
    if (r_state == StSetup) begin
      w_cnt_d = '0;
    end else if (r_state == StAccess && !bus.Pready) begin
      w_cnt_d = r_cnt + 1'b1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_cnt <= '0;
    else      r_cnt <= w_cnt_d;
  end
`else
  assign w_timeout = 1'b0;
`endif

  assign w_complete = bus.Pready || w_timeout;

  // Next-state and output logic for the IDLE/SETUP/ACCESS transfer FSM.
  always_comb begin
    w_state_d   = r_state;
    w_rr_ptr_d  = r_rr_ptr;
    w_gnt_idx_d = r_gnt_idx;
    w_gnt_d     = r_gnt;
    w_psel_d    = r_psel;
    w_penable_d = r_penable;
    w_pwrite_d  = r_pwrite;
    w_paddr_d   = r_paddr;
    w_pwdata_d  = r_pwdata;
    w_done_d    = '0;
    w_rdata_d   = r_rdata;
    w_err_d     = r_err;
    case (r_state)
      StIdle: begin
        if (|bus.req) begin
          // Payload is captured once here; later requester changes are ignored.
          w_gnt_idx_d = w_arb_idx;
          w_gnt_d     = w_arb_gnt;
          w_pwrite_d  = bus.req_write[w_arb_idx];
          w_paddr_d   = bus.req_addr[32'(w_arb_idx) * AW +: AW];
          w_pwdata_d  = bus.req_wdata[32'(w_arb_idx) * DW +: DW];
          w_psel_d    = 1'b1;
          w_state_d   = StSetup;
        end
      end
      StSetup: begin
        w_penable_d = 1'b1;
        w_state_d   = StAccess;
      end
      StAccess: begin
        if (w_complete) begin
          w_done_d    = r_gnt;
          w_rdata_d   = (r_pwrite || w_timeout) ? '0 : bus.Prdata;
          w_err_d     = w_timeout ? 1'b1 : bus.Pslverr;
          w_psel_d    = 1'b0;
          w_penable_d = 1'b0;
          w_rr_ptr_d  = (32'(r_gnt_idx) == NREQ - 1) ? '0 : r_gnt_idx + 1'b1;
          w_state_d   = StIdle;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // State and registered outputs; reset clears everything without a done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= StIdle;
      r_rr_ptr  <= '0;
      r_gnt_idx <= '0;
      r_gnt     <= '0;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_done    <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_rr_ptr  <= w_rr_ptr_d;
      r_gnt_idx <= w_gnt_idx_d;
      r_gnt     <= w_gnt_d;
      r_psel    <= w_psel_d;
      r_penable <= w_penable_d;
      r_pwrite  <= w_pwrite_d;
      r_paddr   <= w_paddr_d;
      r_pwdata  <= w_pwdata_d;
      r_done    <= w_done_d;
      r_rdata   <= w_rdata_d;
      r_err     <= w_err_d;
    end
  end

  assign bus.Psel    = r_psel;
  assign bus.Penable = r_penable;
  assign bus.Pwrite  = r_pwrite;
  assign bus.Paddr   = r_paddr;
  assign bus.Pwdata  = r_pwdata;
  assign bus.done    = r_done;
  assign bus.rdata   = r_rdata;
  assign bus.err     = r_err;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed self-checking bench for apb_req_arbiter (NREQ=2, AW=DW=32).
module tb_apb_req_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  apb_req_arbiter_if #(.NREQ(2), .AW(32), .DW(32)) bus ();

  apb_req_arbiter #(.NREQ(2), .AW(32), .DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_psel"}, 32'(bus.Psel), 32'd0);
    chk({tag, "_penable"}, 32'(bus.Penable), 32'd0);
  endtask

  initial begin
    logic [31:0] exp_addr;
    int          g;
    checks = 0;
    errors = 0;
    rst           = 1'b0;
    bus.req       = '0;
    bus.req_write = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.Prdata    = '0;
    bus.Pready    = 1'b1;
    bus.Pslverr   = 1'b0;

    // Reset state
    tick();
    chk_idle("rst");
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_paddr", bus.Paddr, 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // Single write on requester 0, Pready tied high
    bus.req           = 2'b01;
    bus.req_write     = 2'b01;
    bus.req_addr[31:0]  = 32'h0000_1000;
    bus.req_wdata[31:0] = 32'hDEAD_BEEF;
    bus.Pready        = 1'b1;
    chk_idle("wr_c0");
    tick();
    chk("wr_c1_psel", 32'(bus.Psel), 32'd1);
    chk("wr_c1_penable", 32'(bus.Penable), 32'd0);
    chk("wr_c1_paddr", bus.Paddr, 32'h0000_1000);
    chk("wr_c1_pwdata", bus.Pwdata, 32'hDEAD_BEEF);
    chk("wr_c1_pwrite", 32'(bus.Pwrite), 32'd1);
    tick();
    chk("wr_c2_psel", 32'(bus.Psel), 32'd1);
    chk("wr_c2_penable", 32'(bus.Penable), 32'd1);
    chk("wr_c2_done", 32'(bus.done), 32'd0);
    tick();
    chk("wr_c3_done", 32'(bus.done), 32'b01);
    chk("wr_c3_err", 32'(bus.err), 32'd0);
    chk("wr_c3_rdata", bus.rdata, 32'd0);
    chk_idle("wr_c3");
    bus.req = 2'b00;
    tick();
    chk("wr_c4_done", 32'(bus.done), 32'd0);
    chk_idle("wr_c4");

    // Read on requester 1 with 3 wait states; payload change after grant ignored
    bus.req              = 2'b10;
    bus.req_write        = 2'b00;
    bus.req_addr[63:32]  = 32'h0000_2000;
    bus.Prdata           = 32'hA5A5_A5A5;
    bus.Pready           = 1'b0;
    tick();
    chk("rd_setup_psel", 32'(bus.Psel), 32'd1);
    chk("rd_setup_paddr", bus.Paddr, 32'h0000_2000);
    chk("rd_setup_pwrite", 32'(bus.Pwrite), 32'd0);
    bus.req_addr[63:32] = 32'h0000_3000;
    bus.req_write       = 2'b10;
    for (int a = 1; a <= 4; a++) begin
      tick();
      chk("rd_acc_penable", 32'(bus.Penable), 32'd1);
      chk("rd_acc_done", 32'(bus.done), 32'd0);
      chk("rd_acc_paddr", bus.Paddr, 32'h0000_2000);
      if (a == 4) bus.Pready = 1'b1;
    end
    tick();
    chk("rd_done", 32'(bus.done), 32'b10);
    chk("rd_rdata", bus.rdata, 32'hA5A5_A5A5);
    chk("rd_err", 32'(bus.err), 32'd0);
    chk_idle("rd_end");
    bus.req = 2'b00;
    tick();
    chk("rd_hold_rdata", bus.rdata, 32'hA5A5_A5A5);

    // Contention: both held; grants alternate 0,1,0,1 with an IDLE cycle after each done
    bus.req             = 2'b11;
    bus.req_write       = 2'b11;
    bus.req_addr[31:0]  = 32'h0000_0100;
    bus.req_addr[63:32] = 32'h0000_0200;
    for (int t = 0; t < 4; t++) begin
      g = t % 2;
      exp_addr = (g == 0) ? 32'h0000_0100 : 32'h0000_0200;
      tick();
      chk("ct_setup_paddr", bus.Paddr, exp_addr);
      tick();
      chk("ct_acc_penable", 32'(bus.Penable), 32'd1);
      if (t == 3) bus.req = 2'b00;
      tick();
      chk("ct_done", 32'(bus.done), 32'(1 << g));
      chk("ct_gap_psel", 32'(bus.Psel), 32'd0);
    end
    tick();
    chk_idle("ct_end");

    // Slave error on requester 1 read, then clean write on requester 0
    bus.req        = 2'b10;
    bus.req_write  = 2'b00;
    bus.Prdata     = 32'h1234_5678;
    bus.Pslverr    = 1'b1;
    tick();
    tick();
    tick();
    chk("se_done", 32'(bus.done), 32'b10);
    chk("se_err", 32'(bus.err), 32'd1);
    chk("se_rdata", bus.rdata, 32'h1234_5678);
    bus.req     = 2'b00;
    bus.Pslverr = 1'b0;
    tick();
    chk("se_hold_err", 32'(bus.err), 32'd1);
    bus.req       = 2'b01;
    bus.req_write = 2'b01;
    tick();
    tick();
    tick();
    chk("cl_done", 32'(bus.done), 32'b01);
    chk("cl_err", 32'(bus.err), 32'd0);
    chk("cl_rdata", bus.rdata, 32'd0);
    bus.req = 2'b00;
    tick();

    // Reset during ACCESS (pointer is 1 at this point), then restart from pointer 0
    bus.req             = 2'b01;
    bus.req_write       = 2'b00;
    bus.req_addr[31:0]  = 32'h0000_0300;
    bus.req_addr[63:32] = 32'h0000_0400;
    bus.Pready          = 1'b0;
    tick();
    tick();
    chk("rs_acc_penable", 32'(bus.Penable), 32'd1);
    rst = 1'b0;
    #1;
    chk_idle("rs_async");
    chk("rs_async_paddr", bus.Paddr, 32'd0);
    chk("rs_async_done", 32'(bus.done), 32'd0);
    bus.req = 2'b11;
    tick();
    chk("rs_hold_done", 32'(bus.done), 32'd0);
    chk_idle("rs_hold");
    rst = 1'b1;
    bus.Prdata = 32'hCAFE_F00D;
    tick();
    chk("rs_restart_paddr", bus.Paddr, 32'h0000_0300);
    bus.req    = 2'b01;
    bus.Pready = 1'b1;
    tick();
    tick();
    chk("rs_done", 32'(bus.done), 32'b01);
    chk("rs_rdata", bus.rdata, 32'hCAFE_F00D);
    bus.req = 2'b00;
    tick();

`ifdef APB_TIMEOUT_EN
    // Pready stuck low: abort after 16 ACCESS cycles with err=1, rdata=0
    bus.req    = 2'b01;
    bus.Pready = 1'b0;
    tick();
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk("to_acc_penable", 32'(bus.Penable), 32'd1);
      chk("to_acc_done", 32'(bus.done), 32'd0);
    end
    bus.req = 2'b00;
    tick();
    chk("to_done", 32'(bus.done), 32'b01);
    chk("to_err", 32'(bus.err), 32'd1);
    chk("to_rdata", bus.rdata, 32'd0);
    bus.Pready = 1'b1;
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_req_arbiter.md
Name: apb_req_arbiter

Overview:
Shares the single APB master port (Psel/Penable/Pwrite/Paddr/Pwdata) among NREQ independent requesters, e.g. the AHB-to-APB bridge FSM, a DMA engine and a debug port. Round-robin arbitration; each granted request runs one complete APB transfer (SETUP then ACCESS, with Pready wait states). The result is returned to the owning requester with a one-cycle done pulse. Sits between the bridge-side requesters and the APB slave decode.

Parameters:
NREQ, 2, number of requesters (2..8)
AW, 32, address width
DW, 32, data width
TIMEOUT, 16, max ACCESS cycles without Pready before abort (used only with APB_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
req  in  NREQ  per-requester request; held until matching done
req_write  in  NREQ  per-requester direction, 1=write
req_addr  in  NREQ*AW  packed addresses, requester i at [i*AW +: AW]
req_wdata  in  NREQ*DW  packed write data
done  out  NREQ  one-hot completion pulse
rdata  out  DW  read data, valid with done
err  out  1  error flag, valid with done
Psel  out  1  APB select
Penable  out  1  APB enable
Pwrite  out  1  APB direction
Paddr  out  AW  APB address
Pwdata  out  DW  APB write data
Prdata  in  DW  APB read data
Pready  in  1  APB ready
Pslverr  in  1  APB slave error

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, rr pointer=0, all outputs 0.
- FSM states IDLE, SETUP, ACCESS.
- IDLE: if any req bit set, grant the requester chosen by the rotating-priority search starting at rr_ptr. Latch its write/addr/wdata into Pwrite/Paddr/Pwdata, set Psel=1 and go to SETUP. Otherwise stay in IDLE with Psel=0.
- SETUP: Psel=1, Penable=0, lasting exactly one cycle; then go to ACCESS with Penable=1.
- ACCESS: hold Psel=1, Penable=1 and all address/data until Pready=1. In the Pready cycle, on the next edge:
  - done[gnt]=1 for one cycle;
  - rdata=Prdata for reads, 0 for writes;
  - err=Pslverr;
  - Psel=Penable=0;
  - rr_ptr=gnt+1, wrapping from NREQ-1 to 0;
  - return to IDLE.
- Minimum transfer: req sampled in cycle 0; SETUP in cycle 1; ACCESS in cycle 2; done in cycle 3 with Pready=1 in cycle 2. There is always at least one IDLE cycle between transfers, so Psel deasserts for at least one cycle.
- Payload is sampled only at grant; requester changes afterward are ignored until done.
- A req dropped after grant does not abort the transfer; done is still pulsed.
- Simultaneous requests: the lowest index at or after rr_ptr wins. A requester that re-asserts req in the cycle after its done waits behind the other pending requesters.
- rdata/err hold their last values between done pulses.
- Reset asserted mid-transfer: immediate return to IDLE with all outputs 0; no done pulse.

Optional Feature:
APB_TIMEOUT_EN
- Defined: a counter of width clog2(TIMEOUT+1) clears on entry to ACCESS and increments each ACCESS cycle with Pready=0. When it reaches TIMEOUT, the transfer ends as if Pready=1, with err=1 and rdata=0.
- Undefined: no counter; ACCESS waits for Pready indefinitely.

Decomposition:
- Package apb_arb_pkg: state encoding constants (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2), default AW/DW widths, and a clog2 function.
- Sub-module apb_rr_arbiter: combinational rotating-priority select. Inputs req and rr_ptr; outputs one-hot grant and the granted index.

Test Plan:
- Single write: req=01, addr0=0x1000, wdata0=0xDEADBEEF, Pready tied 1 -> Psel in cycles 1-2, Penable in cycle 2, Paddr=0x1000, Pwdata=0xDEADBEEF, done=01 in cycle 3, err=0.
- Read with 3 wait states: req=10, read, Prdata=0xA5A5A5A5 with Pready high on the 4th ACCESS cycle -> Penable held 4 cycles, done=10, rdata=0xA5A5A5A5.
- Contention: req=11 held continuously -> grants alternate 0,1,0,1; every done is followed by at least one Psel=0 cycle.
- Slave error: Pslverr=1 with Pready -> err=1 with done; next clean transfer gives err=0.
- Reset during ACCESS: rst low with Pready=0 -> all outputs 0 immediately, no done; after release, a pending req starts from rr_ptr=0.
- APB_TIMEOUT_EN, TIMEOUT=16, Pready stuck 0 -> done after 16 ACCESS cycles with err=1, rdata=0.
